// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Purpose:
//   Pipelined carry-lookahead adder. A WIDTH-bit add is split into
//   NUM_STAGES = WIDTH/(4*GROUPS_PER_STAGE) register stages. Each stage
//   resolves GROUPS_PER_STAGE 4-bit lookahead groups using group
//   generate/propagate, and hands its registered carry to the next stage.
//   Upper operand slices travel forward with the word, so each stage only
//   sees the slice it resolves. Sum bits that are already resolved travel
//   forward as well. A single global stall freezes every stage at once,
//   so words are never dropped, duplicated or reordered.
//
// Parameters:
//   WIDTH            operand/sum width, a multiple of 4*GROUPS_PER_STAGE
//   GROUPS_PER_STAGE 4-bit lookahead groups resolved per stage
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all valid bits
//   in_valid   operands present
//   in_ready   stage 0 can accept (= !stall, combinational on out_ready)
//   a, b       operands
//   c_in       carry into bit 0
//   sub        (only with CLA_PIPE_SUB_EN) 1 selects a - b, c_in ignored
//   out_valid  result present
//   out_ready  downstream accepts
//   sum        result, modulo 2^WIDTH
//   c_out      carry out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   ovf        signed overflow, carry(WIDTH-1) ^ carry(WIDTH)
//
// Build option:
//   CLA_PIPE_SUB_EN  adds the sub port and the subtract mode
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int WIDTH            = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SLICE      = 4 * GROUPS_PER_STAGE;
  localparam int NUM_STAGES = WIDTH / SLICE;

  // One 4-bit lookahead group: returns {carry_out, sum[3:0]}.
  // Group carry = G_grp | P_grp & carry_in.
  function automatic logic [4:0] cla_group(input logic [3:0] ga,
                                            input logic [3:0] gb,
                                            input logic       cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       g_grp;
    logic       p_grp;
    p     = ga ^ gb;
    g     = ga & gb;
    c[0]  = cin;
    c[1]  = g[0] | (p[0] & cin);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & cin);
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
    return {g_grp | (p_grp & cin), p ^ c};
  endfunction

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Stall is global: the whole pipe freezes, bubbles included.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

`ifdef CLA_PIPE_SUB_EN
  // a - b = a + ~b + 1; the inverted b slices travel down the pipe.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;
`else
  assign b_eff   = b;
  assign cin_eff = c_in;
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO   = SLICE * k;
    localparam int DONE = LO + SLICE;
    localparam int REM  = WIDTH - DONE;

    // src_a/src_b hold the operand bits not yet consumed; the low
    // SLICE bits are this stage's slice.
    logic [WIDTH-LO-1:0] src_a;
    logic [WIDTH-LO-1:0] src_b;
    logic                cin_s;
    logic                vin_s;
    logic [SLICE-1:0]    sum_s;
    logic                cout_s;
    logic                c_chain;
    logic [4:0]          grp;
    logic [DONE-1:0]     sum_d;
    logic [DONE-1:0]     sum_q;
    logic                valid_d;
    logic                valid_q;
    logic                carry_d;
    logic                carry_q;

    if (k == 0) begin : g_head
      assign src_a = a;
      assign src_b = b_eff;
      assign cin_s = cin_eff;
      assign vin_s = in_valid;
      assign sum_d = sum_s;
    end else begin : g_body
      assign src_a = g_stage[k-1].g_ops.a_q;
      assign src_b = g_stage[k-1].g_ops.b_q;
      assign cin_s = g_stage[k-1].carry_q;
      assign vin_s = g_stage[k-1].valid_q;
      assign sum_d = {sum_s, g_stage[k-1].sum_q};
    end

    // GROUPS_PER_STAGE groups chained through their group carries.
    always_comb begin
      c_chain = cin_s;
      sum_s   = '0;
      grp     = '0;
      for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
        grp              = cla_group(src_a[4*j +: 4], src_b[4*j +: 4], c_chain);
        sum_s[4*j +: 4]  = grp[3:0];
        c_chain          = grp[4];
      end
      cout_s = c_chain;
    end

    assign valid_d = vin_s;
    assign carry_d = cout_s;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!stall) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    // Operand skew registers: only the slices later stages still need.
    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      assign a_d = src_a[WIDTH-LO-1:SLICE];
      assign b_d = src_b[WIDTH-LO-1:SLICE];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit, so the
    // overflow flag needs no extra carry tap out of the group logic.
    if (k == NUM_STAGES - 1) begin : g_tail
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = src_a[SLICE-1] ^ src_b[SLICE-1] ^ sum_s[SLICE-1] ^ cout_s;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].valid_q;
  assign sum       = g_stage[NUM_STAGES-1].sum_q;
  assign c_out     = g_stage[NUM_STAGES-1].carry_q;
  assign ovf       = g_stage[NUM_STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Bench for pipelined_cla_adder at WIDTH=16, GROUPS_PER_STAGE=1 (4 stages).
// Directed cases plus a randomized stream, checked against an arithmetic
// reference model and an in-order queue of expected results.
// ---------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         c_in_r;
  logic         sub_r;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  always #5 clk = ~clk;

  pipelined_cla_adder #(
    .WIDTH(W),
    .GROUPS_PER_STAGE(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a_r),
    .b(b_r),
    .c_in(c_in_r),
`ifdef CLA_PIPE_SUB_EN
    .sub(sub_r),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .c_out(c_out),
    .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  int           tests_run = 0;
  int           fails     = 0;
  exp_t         q[$];
  logic [W-1:0] out_log[$];
  logic         prev_stall = 1'b0;
  logic [W+1:0] prev_out;
  logic         last_acc;

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic ci, logic sb);
    exp_t r;
    int   ux, uy, sx, sy, full, sres;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      full = ux - uy;
      r.s  = full[W-1:0];
      r.co = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy + int'(ci);
      r.s  = full[W-1:0];
      r.co = full[W];
      sres = sx + sy + int'(ci);
    end
    r.ov = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: settle, check handshake/hold, score transfers, advance.
  task automatic cycle();
    exp_t e;
    logic acc, outx;
    #1;
    if (rst_n) begin
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({ovf, c_out, sum}), 32'(prev_out));
      end
    end
    acc  = rst_n && in_valid && in_ready;
    outx = rst_n && out_valid && out_ready;
    if (outx) begin
      check("no_stale", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_sum", 32'(sum), 32'(e.s));
        check("sb_cout", 32'(c_out), 32'(e.co));
        check("sb_ovf", 32'(ovf), 32'(e.ov));
      end
      out_log.push_back(sum);
    end
    if (acc) q.push_back(model(a_r, b_r, c_in_r, sub_r));
    last_acc   = acc;
    prev_stall = rst_n && out_valid && !out_ready;
    prev_out   = {ovf, c_out, sum};
    @(posedge clk);
    #1;
  endtask

  // Single word into an empty pipe; checks latency and directed values.
  task automatic send_one(logic [W-1:0] x, logic [W-1:0] y, logic ci,
                          logic sb, logic [W-1:0] es, logic eco, logic eov);
    int n;
    a_r       = x;
    b_r       = y;
    c_in_r    = ci;
    sub_r     = sb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check("dir_sum", 32'(sum), 32'(es));
    check("dir_cout", 32'(c_out), 32'(eco));
    check("dir_ovf", 32'(ovf), 32'(eov));
    cycle();
  endtask

  initial begin
    int base, nsent;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_r       = '0;
    b_r       = '0;
    c_in_r    = 1'b0;
    sub_r     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef CLA_PIPE_SUB_EN
    send_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Back-pressure: 6 words n+n, downstream stalls in cycles 5..8.
    base  = out_log.size();
    nsent = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid  = (nsent < 6);
      a_r       = W'(nsent + 1);
      b_r       = W'(nsent + 1);
      c_in_r    = 1'b0;
      sub_r     = 1'b0;
      out_ready = !(i >= 5 && i <= 8);
      cycle();
      if (last_acc) nsent++;
    end
    in_valid = 1'b0;
    check("bp_count", 32'(out_log.size() - base), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (base + k < out_log.size())
        check("bp_order", 32'(out_log[base+k]), 32'(2 * (k + 1)));
    end

    // Reset mid-flight: 3 words accepted, first one parked at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_r      = W'(i + 10);
      b_r      = W'(i + 20);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_sum", 32'(sum), 32'd0);
    check("rst_mid_cout", 32'(c_out), 32'd0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    q.delete();
    prev_stall = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    a_r        = 16'hDEAD;
    b_r        = 16'h0001;
    cycle();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    base     = out_log.size();
    repeat (10) cycle();
    check("rst_no_stale", 32'(out_log.size()), 32'(base));
    send_one(16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);

    // Randomized stream with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_r       = W'($urandom);
      b_r       = W'($urandom);
      c_in_r    = 1'($urandom);
`ifdef CLA_PIPE_SUB_EN
      sub_r     = 1'($urandom);
`endif
      cycle();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

- Parametrised, pipelined carry-lookahead adder built from 4-bit lookahead groups.
- Splits a `WIDTH`-bit add into `NUM_STAGES = WIDTH/(4*GROUPS_PER_STAGE)` register stages. Each stage resolves `GROUPS_PER_STAGE` groups using group generate/propagate and hands its registered carry to the next stage.
- Uses a valid/ready handshake and full back-pressure.
- Sits in the datapath wherever wide adds must close timing at high clock rates. It is the successor to the single-cycle 4-bit lookahead group.

## Interface
Parameters:
- `WIDTH`, 32, operand/sum width; must be a multiple of `4*GROUPS_PER_STAGE`.
- `GROUPS_PER_STAGE`, 2, number of 4-bit lookahead groups resolved per pipeline stage.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands present.
- `in_ready` out 1: stage 0 can accept.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B.
- `c_in` in 1: carry into bit 0.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts.
- `sum` out `WIDTH`: result.
- `c_out` out 1: carry out of bit `WIDTH-1`.
- `ovf` out 1: signed overflow, `carry(WIDTH-1) ^ carry(WIDTH)`.
- `sub` in 1: present only with `CLA_PIPE_SUB_EN`; 1 selects A−B.

## Operation
- **Input transfer:** when `in_valid && in_ready`.
- **Output transfer:** when `out_valid && out_ready`.
- **Stage k (0..`NUM_STAGES`−1):**
  - Takes the stage-k carry (stage 0 uses `c_in`).
  - Computes bits `[4*G*k +: 4*G]` with per-group lookahead: group carry = G_grp | P_grp & carry_prev.
  - Registers the partial sum bits, the carry out, the unprocessed operand slices and a valid bit.
- **Operand skew:** upper operand slices travel with the pipeline, so each stage consumes exactly the slice it resolves. Already-resolved sum bits also travel forward.
- **Final stage:** its registers drive `sum`, `c_out`, `ovf` and `out_valid`.
- **Stall:** `stall = out_valid && !out_ready`.
  - While stalled, every stage register holds, including bubbles, and `in_ready` = 0.
  - `in_ready = !stall`. The pipeline never advances partially and never drops or duplicates a word.
- **Bubbles:** a stage with valid=0 propagates valid=0. Data registers may load don't-care values but must not cause `out_valid`.
- **Width rules:**
  - Arithmetic is modulo 2^`WIDTH`.
  - `c_out` is the true carry out of the top bit.
  - `ovf` uses the carry into and the carry out of the MSB.
- **Reset:** `rst_n` low, including mid-operation, clears all valid bits immediately, so in-flight words are lost.
  - `sum`, `c_out`, `ovf` and `out_valid` reset to 0.
  - `in_ready` reads 1 once `out_valid` is 0.
  - Transfers offered while `rst_n` is low are ignored.

## Timing
- **Latency:** exactly `NUM_STAGES` cycles from the input-transfer edge to `out_valid`=1, absent stalls.
  - Example: `WIDTH`=32, `GROUPS_PER_STAGE`=2 gives 4 cycles.
- **Throughput:** one word per cycle when `out_ready` is held 1.
- **Output stability:** `out_valid` and the result stay stable until an output transfer.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. There are no other combinational input-to-output paths.
- **Critical path per stage:** `GROUPS_PER_STAGE` chained group-lookahead evaluations.
- **Ordering:** results leave in acceptance order.

## Configuration
- `CLA_PIPE_SUB_EN` defined:
  - The `sub` port exists and is sampled with the operands.
  - When `sub`=1, stage 0 uses ~B and the carry-in is forced to 1, so `sum = A−B` and `c_out` = 1 means no borrow. `c_in` is ignored.
  - `ovf` reflects signed subtract overflow.
- `CLA_PIPE_SUB_EN` undefined:
  - The `sub` port is absent.
  - The block only computes `A+B+c_in`.

## Test plan
All scenarios use `WIDTH`=16, `GROUPS_PER_STAGE`=1 (4 stages) unless noted.
- **Single add:** `a`=0x1234, `b`=0x4321, `c_in`=0 →
  - `out_valid` exactly 4 cycles later.
  - `sum`=0x5555, `c_out`=0, `ovf`=0.
- **Full carry ripple:** `a`=0xFFFF, `b`=0x0000, `c_in`=1 → `sum`=0x0000, `c_out`=1, `ovf`=0.
- **Signed overflow:** `a`=0x7FFF, `b`=0x0001 → `sum`=0x8000, `ovf`=1, `c_out`=0.
- **Back-pressure:**
  - Stimulus: stream 6 words `a`=n, `b`=n (n=1..6) with `out_ready`=0 in cycles 5–8.
  - `in_ready`=0 while `out_valid`=1 and `out_ready`=0.
  - Outputs 2,4,6,8,10,12 appear in order, with no loss or duplication.
- **Reset mid-flight:**
  - Stimulus: accept 3 words, then pulse `rst_n` low for 1 cycle.
  - All outputs read 0 immediately.
  - No stale word appears afterwards.
  - The next accepted word emerges after 4 cycles.
- **`CLA_PIPE_SUB_EN` defined:**
  - `sub`=1, `a`=0x0005, `b`=0x0007 → `sum`=0xFFFE, `c_out`=0.
  - `sub`=1, `a`=0x8000, `b`=0x0001 → `ovf`=1.
